// File: rtl/mem_stage_dm.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_dm
//  Purpose  : M-stage data memory with sub-word stores and sign/zero-extended
//             loads. Load data is registered into the M/W boundary.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_dm #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr_m,
   input  logic [31:0] wdata_m,
   input  logic        mem_write_m,
   input  logic        mem_read_m,
   input  logic [1:0]  store_type_m,
   input  logic [2:0]  load_type_m,
   output logic [31:0] rdata_w,
   output logic        addr_err_w,
   output logic [3:0]  be_m
);

   localparam logic [1:0] c_st_word  = 2'd1;
   localparam logic [1:0] c_st_half  = 2'd2;
   localparam logic [1:0] c_st_byte  = 2'd3;

   localparam logic [2:0] c_ld_word  = 3'd0;
   localparam logic [2:0] c_ld_hs    = 3'd1;
   localparam logic [2:0] c_ld_hu    = 3'd2;
   localparam logic [2:0] c_ld_bs    = 3'd3;
   localparam logic [2:0] c_ld_bu    = 3'd4;

   logic [31:0]   r_mem [DEPTH];
   logic [31:0]   r_rdata;
   logic          r_err;

   logic [AW-1:0] w_idx;
   logic          w_out_of_range;
   logic          w_mis_st;
   logic          w_mis_ld;
   logic          w_ill_ld;
   logic          w_err;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata_rep;
   logic [31:0]   w_word;
   logic [31:0]   w_shifted;
   logic [15:0]   w_half;
   logic [7:0]    w_byte;
   logic [31:0]   w_ext;
   logic [31:0]   w_rdata_next;

   assign w_idx          = addr_m[AW+1:2];
   assign w_out_of_range = (addr_m >> 2) >= 32'(DEPTH);

   // Alignment and legality are judged against whichever access is enabled.
   always_comb begin
      w_mis_st = 1'b0;
      w_mis_ld = 1'b0;
      w_ill_ld = 1'b0;
      if (mem_write_m) begin
         case (store_type_m)
            c_st_word: w_mis_st = (addr_m[1:0] != 2'b00);
            c_st_half: w_mis_st = addr_m[0];
            default:   w_mis_st = 1'b0;
         endcase
      end
      if (mem_read_m) begin
         case (load_type_m)
            c_ld_word:        w_mis_ld = (addr_m[1:0] != 2'b00);
            c_ld_hs, c_ld_hu: w_mis_ld = addr_m[0];
            c_ld_bs, c_ld_bu: w_mis_ld = 1'b0;
            default:          w_ill_ld = 1'b1;
         endcase
      end
   end

   assign w_err = (mem_write_m | mem_read_m)
                & (w_out_of_range | w_mis_st | w_mis_ld | w_ill_ld);

   always_comb begin
      w_be        = 4'b0000;
      w_wdata_rep = wdata_m;
      case (store_type_m)
         c_st_word: w_be = 4'b1111;
         c_st_half: begin
            w_be        = 4'b0011 << addr_m[1:0];
            w_wdata_rep = {wdata_m[15:0], wdata_m[15:0]};
         end
         c_st_byte: begin
            w_be        = 4'b0001 << addr_m[1:0];
            w_wdata_rep = {4{wdata_m[7:0]}};
         end
         default: w_be = 4'b0000;
      endcase
      if (!mem_write_m || w_err) begin
         w_be = 4'b0000;
      end
   end

   assign be_m = w_be;

   // Combinational fetch sees the pre-write word, giving read-before-write.
   assign w_word    = r_mem[w_idx];
   assign w_shifted = w_word >> {addr_m[1:0], 3'b000};
   assign w_half    = w_shifted[15:0];
   assign w_byte    = w_shifted[7:0];

   always_comb begin
      w_ext = 32'h0;
      case (load_type_m)
         c_ld_word: w_ext = w_word;
         c_ld_hs:   w_ext = {{16{w_half[15]}}, w_half};
         c_ld_hu:   w_ext = {16'h0, w_half};
         c_ld_bs:   w_ext = {{24{w_byte[7]}}, w_byte};
         c_ld_bu:   w_ext = {24'h0, w_byte};
         default:   w_ext = 32'h0;
      endcase
   end

   assign w_rdata_next = (mem_read_m && !w_err) ? w_ext : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'h0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_be[k]) begin
               r_mem[w_idx][8*k +: 8] <= w_wdata_rep[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_rdata <= w_rdata_next;
         r_err   <= w_err;
      end
   end

   assign rdata_w    = r_rdata;
   assign addr_err_w = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_dm
//  Purpose  : Directed, table-driven self-checking bench for mem_stage_dm.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_dm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr_m;
   logic [31:0] wdata_m;
   logic        mem_write_m;
   logic        mem_read_m;
   logic [1:0]  store_type_m;
   logic [2:0]  load_type_m;
   logic [31:0] rdata_w;
   logic        addr_err_w;
   logic [3:0]  be_m;

   int n_cmp = 0;
   int n_bad = 0;

   mem_stage_dm #(.DEPTH(1024), .AW(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .addr_m       (addr_m),
      .wdata_m      (wdata_m),
      .mem_write_m  (mem_write_m),
      .mem_read_m   (mem_read_m),
      .store_type_m (store_type_m),
      .load_type_m  (load_type_m),
      .rdata_w      (rdata_w),
      .addr_err_w   (addr_err_w),
      .be_m         (be_m)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        re;
      logic [1:0]  st;
      logic [2:0]  lt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic we, logic re, logic [1:0] st, logic [2:0] lt,
                               logic [31:0] addr, logic [31:0] wdata,
                               logic [3:0] be, logic [31:0] rd, logic err);
      vec_t v;
      v.we = we; v.re = re; v.st = st; v.lt = lt;
      v.addr = addr; v.wdata = wdata; v.be = be; v.rd = rd; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one M-stage access, check be_m before the edge and W-stage outputs after.
   task automatic apply(input vec_t v, input int idx, input logic rst);
      @(negedge clk);
      reset        = rst;
      mem_write_m  = v.we;
      mem_read_m   = v.re;
      store_type_m = v.st;
      load_type_m  = v.lt;
      addr_m       = v.addr;
      wdata_m      = v.wdata;
      #1;
      chk("be_m", idx, {28'h0, be_m}, {28'h0, v.be});
      @(posedge clk);
      #1;
      chk("rdata_w", idx, rdata_w, v.rd);
      chk("addr_err_w", idx, {31'h0, addr_err_w}, {31'h0, v.err});
   endtask

   // Shorthands: store (we, store_type) and load (re, load_type).
   function automatic vec_t st_v(logic [1:0] st, logic [31:0] a, logic [31:0] d,
                                 logic [3:0] be, logic err);
      return mk(1'b1, 1'b0, st, 3'd0, a, d, be, 32'h0, err);
   endfunction

   function automatic vec_t ld_v(logic [2:0] lt, logic [31:0] a, logic [31:0] rd,
                                 logic err);
      return mk(1'b0, 1'b1, 2'd0, lt, a, 32'h0, 4'b0000, rd, err);
   endfunction

   initial begin
      reset = 1'b1; addr_m = '0; wdata_m = '0; mem_write_m = 1'b0;
      mem_read_m = 1'b0; store_type_m = '0; load_type_m = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdata", 0, rdata_w, 32'h0);
      chk("reset_err", 0, {31'h0, addr_err_w}, 32'h0);

      vecs.push_back(ld_v(3'd0, 32'h0000_0000, 32'h0000_0000, 1'b0));
      vecs.push_back(st_v(2'd1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 1'b0));
      vecs.push_back(ld_v(3'd0, 32'h0000_0010, 32'h1234_5678, 1'b0));
      vecs.push_back(st_v(2'd3, 32'h0000_0011, 32'h0000_00AB, 4'b0010, 1'b0));
      vecs.push_back(ld_v(3'd0, 32'h0000_0010, 32'h1234_AB78, 1'b0));
      vecs.push_back(ld_v(3'd3, 32'h0000_0011, 32'hFFFF_FFAB, 1'b0));
      vecs.push_back(ld_v(3'd4, 32'h0000_0011, 32'h0000_00AB, 1'b0));
      vecs.push_back(st_v(2'd2, 32'h0000_0012, 32'h0000_8001, 4'b1100, 1'b0));
      vecs.push_back(ld_v(3'd1, 32'h0000_0012, 32'hFFFF_8001, 1'b0));
      vecs.push_back(ld_v(3'd2, 32'h0000_0012, 32'h0000_8001, 1'b0));
      vecs.push_back(ld_v(3'd0, 32'h0000_0010, 32'h8001_AB78, 1'b0));
      vecs.push_back(st_v(2'd1, 32'h0000_0021, 32'hFFFF_FFFF, 4'b0000, 1'b1));
      vecs.push_back(ld_v(3'd0, 32'h0000_0020, 32'h0000_0000, 1'b0));
      vecs.push_back(ld_v(3'd1, 32'h0000_0013, 32'h0000_0000, 1'b1));
      vecs.push_back(ld_v(3'd0, 32'h0000_1000, 32'h0000_0000, 1'b1));
      vecs.push_back(st_v(2'd1, 32'h0000_1000, 32'h5555_5555, 4'b0000, 1'b1));
      vecs.push_back(ld_v(3'd0, 32'h0000_0000, 32'h0000_0000, 1'b0));
      vecs.push_back(st_v(2'd3, 32'h0000_0013, 32'h0000_00C3, 4'b1000, 1'b0));
      vecs.push_back(ld_v(3'd3, 32'h0000_0013, 32'hFFFF_FFC3, 1'b0));
      vecs.push_back(ld_v(3'd4, 32'h0000_0012, 32'h0000_0001, 1'b0));
      vecs.push_back(ld_v(3'd3, 32'h0000_0010, 32'h0000_0078, 1'b0));
      vecs.push_back(ld_v(3'd1, 32'h0000_0010, 32'hFFFF_AB78, 1'b0));
      vecs.push_back(ld_v(3'd5, 32'h0000_0010, 32'h0000_0000, 1'b1));
      vecs.push_back(st_v(2'd0, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 2'd1, 3'd0, 32'h0000_0010, 32'h0, 4'b0000, 32'h0, 1'b0));
      vecs.push_back(ld_v(3'd0, 32'h0000_0012, 32'h0000_0000, 1'b1));
      vecs.push_back(st_v(2'd2, 32'h0000_0011, 32'h0000_7777, 4'b0000, 1'b1));
      vecs.push_back(ld_v(3'd0, 32'h0000_0010, 32'hC301_AB78, 1'b0));
      vecs.push_back(ld_v(3'd0, 32'h8000_0010, 32'h0000_0000, 1'b1));
      vecs.push_back(st_v(2'd2, 32'h0000_0016, 32'h0000_BEEF, 4'b1100, 1'b0));
      vecs.push_back(ld_v(3'd0, 32'h0000_0014, 32'hBEEF_0000, 1'b0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i + 1, 1'b0);
      end

      // Simultaneous load and store to one word: the load returns the old data.
      apply(st_v(2'd1, 32'h0000_0040, 32'h1111_1111, 4'b1111, 1'b0), 100, 1'b0);
      apply(mk(1'b1, 1'b1, 2'd1, 3'd0, 32'h0000_0040, 32'h2222_2222,
               4'b1111, 32'h1111_1111, 1'b0), 101, 1'b0);
      apply(ld_v(3'd0, 32'h0000_0040, 32'h2222_2222, 1'b0), 102, 1'b0);

      // Reset arriving with a store: W-stage outputs clear and the store is dropped.
      apply(st_v(2'd1, 32'h0000_0008, 32'h0BAD_F00D, 4'b1111, 1'b0), 200, 1'b0);
      apply(ld_v(3'd0, 32'h0000_0008, 32'h0BAD_F00D, 1'b0), 201, 1'b0);
      apply(st_v(2'd1, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111, 1'b0), 202, 1'b1);
      apply(ld_v(3'd0, 32'h0000_0008, 32'h0000_0000, 1'b0), 203, 1'b0);
      apply(ld_v(3'd0, 32'h0000_0040, 32'h0000_0000, 1'b0), 204, 1'b0);

      // Error flag followed by reset: reset must clear it.
      apply(ld_v(3'd0, 32'h0000_0003, 32'h0000_0000, 1'b1), 300, 1'b0);
      apply(mk(1'b0, 1'b1, 2'd0, 3'd0, 32'h0000_0003, 32'h0,
               4'b0000, 32'h0, 1'b0), 301, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage_dm.md
Name: mem_stage_dm

Overview:
- Data-memory block of the M stage in the 5-stage pipeline.
- Consumes the M-stage memory-write enable, access type, ALU address and store data.
- Performs word/half/byte stores with byte enables, and word/half/byte loads with sign or zero extension.
- Registers load data into the M/W boundary for the W-stage write-back mux.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- AW, 10, word-index width, log2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- addr_m  in  32  byte address from E/M register (ALU result)
- wdata_m  in  32  store data (rt, already forwarded)
- mem_write_m  in  1  store enable
- mem_read_m  in  1  load enable
- store_type_m  in  2  0 none, 1 word, 2 half, 3 byte
- load_type_m  in  3  0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5-7 illegal
- rdata_w  out  32  extended load data, registered (M/W)
- addr_err_w  out  1  registered misaligned/out-of-range flag
- be_m  out  4  combinational byte enables of the current store, for debug/bench

Behaviour:
- Reset, synchronous at posedge:
  - every memory word becomes 0.
  - rdata_w = 0, addr_err_w = 0.
  - any store presented in the same cycle is discarded.
- Storage: DEPTH x 32 register array, indexed by addr_m[AW+1:2]. Little-endian byte lanes: lane k = bits 8k+7:8k.
- Range check: out_of_range = (addr_m >> 2) >= DEPTH.
- Alignment check:
  - word access needs addr_m[1:0] = 0.
  - half access needs addr_m[0] = 0.
  - byte access is always aligned.
- err_m = (mem_write_m | mem_read_m) & (out_of_range | misaligned | illegal load_type).
- Byte enables (zero if mem_write_m = 0 or err_m = 1):
  - word: 4'b1111.
  - half: 4'b0011 << addr_m[1:0].
  - byte: 4'b0001 << addr_m[1:0].
  - store_type 0 with mem_write_m = 1: be_m = 0, no error.
- Store data lane replication:
  - half: {wdata[15:0], wdata[15:0]}.
  - byte: wdata[7:0] replicated 4 times.
- Write timing: at posedge, only enabled lanes update. The new value is visible to a read in the next cycle.
- Read path:
  - combinational word fetch at the current index.
  - lane select by addr_m[1:0], then extension per load_type_m.
  - result registered into rdata_w at posedge. Load latency is 1 cycle: data appears in the W stage.
- rdata_w is 0 when mem_read_m = 0 or err_m = 1.
- addr_err_w <= err_m every non-reset cycle.
- Simultaneous mem_read_m and mem_write_m at the same address: the read returns the OLD word (read-before-write). The new value is visible from the next access.
- Erroneous store: memory unchanged; the error is reported only through addr_err_w. Exception handling is downstream.
- Reset mid-store: reset wins; the write is dropped.
- No internal FSM beyond the array and the M/W register. No stall input: the pipeline freezes upstream by presenting mem_write_m = mem_read_m = 0 (bubble).

Test Plan:
- Reset then lw at 0x0 -> rdata_w = 0x00000000 next cycle, addr_err_w = 0.
- sw 0x12345678 at 0x10, then lw 0x10 -> rdata_w = 0x12345678.
- Byte/half stores and loads:
  - After sw 0x12345678 at 0x10: sb 0xAB at 0x11, then lw 0x10 -> 0x1234AB78, be_m during the sb = 4'b0010.
  - Then lb 0x11 -> 0xFFFFFFAB; lbu 0x11 -> 0x000000AB.
  - sh 0x8001 at 0x12, then lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001; lw 0x10 -> 0x8001AB78.
- Misaligned and out-of-range accesses:
  - sw at 0x21 -> be_m = 0, addr_err_w = 1 next cycle, memory unchanged.
  - lh at 0x13 -> rdata_w = 0, addr_err_w = 1.
  - With DEPTH = 1024, access at 0x1000 -> addr_err_w = 1.
- Same-cycle lw and sw at 0x40 (old 0x11111111, new 0x22222222) -> rdata_w = 0x11111111; the following lw returns 0x22222222.
- sw 0xDEADBEEF at 0x8 with reset high in the same cycle -> after reset, lw 0x8 returns 0x00000000, rdata_w and addr_err_w are 0 during the reset cycle.
